config_stream_tx: RTL and testbench

Configuration transmitter for the tracing datapath. It buffers a host-supplied firmware block for one instrumentation unit, then drops `tracing` and emits the block as a gap-free byte burst on `configId`/`configData`. Every datapath block that holds a `PERSONAL_CONFIG_ID` receives this burst. The block sits between the host/control interface and the broadcast config bus that fans out to all datapath units.

---
 rtl/config_stream_tx_if.sv | 25 ++
 rtl/config_stream_tx.sv | 198 +++++++++++++++++++
 tb/tb_config_stream_tx.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_stream_tx_if.sv
// config_stream_tx_if: host-side command and firmware-byte valid/ready channels
// between the control interface (master) and config_stream_tx (slave).
interface config_stream_tx_if #(
  parameter int MAX_BYTES = 16
) ();
  localparam int LW = $clog2(MAX_BYTES + 1);

  logic          cmd_valid;
  logic          cmd_ready;
  logic [7:0]    cmd_id;
  logic [LW-1:0] cmd_len;
  logic          byte_valid;
  logic          byte_ready;
  logic [7:0]    byte_data;

  modport master (
    output cmd_valid, cmd_id, cmd_len, byte_valid, byte_data,
    input  cmd_ready, byte_ready
  );

  modport slave (
    input  cmd_valid, cmd_id, cmd_len, byte_valid, byte_data,
    output cmd_ready, byte_ready
  );
endinterface

// File: rtl/config_stream_tx.sv
// config_stream_tx: buffers one firmware block, drops tracing and broadcasts the block
// as a gap-free burst on configId/configData. Define CONFIG_TX_ABORT_EN to add an abort input.
module config_stream_tx #(
  parameter int         MAX_BYTES    = 16,
  parameter logic [7:0] NULL_ID      = 8'hFF,
  parameter int         GUARD_CYCLES = 2,
  localparam int        LW           = $clog2(MAX_BYTES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef CONFIG_TX_ABORT_EN
  input  logic              abort,
`endif
  config_stream_tx_if.slave host,
  output logic              tracing,
  output logic [7:0]        configId,
  output logic [7:0]        configData,
  output logic              busy,
  output logic              err_len
);
  localparam int            IW         = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [LW-1:0] MAX_LEN    = LW'(MAX_BYTES);
  localparam logic [LW-1:0] ONE_L      = LW'(1);
  localparam logic [3:0]    GUARD_LAST = 4'(GUARD_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_TRACE = 3'd0,
    ST_LOAD  = 3'd1,
    ST_GUARD = 3'd2,
    ST_SEND  = 3'd3,
    ST_GAP   = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          session_q, session_d;
  logic [7:0]    id_q, id_d;
  logic [LW-1:0] len_q, len_d;
  logic [LW-1:0] cnt_q, cnt_d;
  logic [3:0]    gcnt_q, gcnt_d;
  logic [7:0]    fw_buf_q [MAX_BYTES];
  logic          tracing_q, tracing_d;
  logic [7:0]    cfg_id_q, cfg_id_d;
  logic [7:0]    cfg_data_q, cfg_data_d;
  logic          busy_q, busy_d;
  logic          err_len_q, err_len_d;
  logic          cmd_ready_s, byte_ready_s, cmd_hs_s, byte_hs_s, len_ok_s, buf_we_s;

  assign cmd_ready_s     = (state_q == ST_TRACE) || (state_q == ST_GAP);
  assign byte_ready_s    = (state_q == ST_LOAD);
  assign cmd_hs_s        = host.cmd_valid && cmd_ready_s;
  assign byte_hs_s       = host.byte_valid && byte_ready_s;
  assign len_ok_s        = (host.cmd_len != '0) && (host.cmd_len <= MAX_LEN);
  assign host.cmd_ready  = cmd_ready_s;
  assign host.byte_ready = byte_ready_s;

  // Next state, counters and buffer write enable
  always_comb begin
    state_d   = state_q;
    session_d = session_q;
    id_d      = id_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    gcnt_d    = gcnt_q;
    err_len_d = 1'b0;
    buf_we_s  = 1'b0;
    case (state_q)
      ST_TRACE, ST_GAP: begin
        if (cmd_hs_s && len_ok_s) begin
          id_d      = host.cmd_id;
          len_d     = host.cmd_len;
          cnt_d     = '0;
          session_d = (state_q == ST_GAP);
          state_d   = ST_LOAD;
        end else if (cmd_hs_s) begin
          err_len_d = 1'b1;
          state_d   = ST_TRACE;
        end else begin
          state_d   = ST_TRACE;
        end
      end
      ST_LOAD: begin
`ifdef CONFIG_TX_ABORT_EN
        if (abort) begin
          cnt_d   = '0;
          state_d = session_q ? ST_GAP : ST_TRACE;
        end else
`endif
        if (byte_hs_s) begin
          buf_we_s = 1'b1;
          if (cnt_q == len_q - ONE_L) begin
            cnt_d   = '0;
            gcnt_d  = 4'd0;
            state_d = session_q ? ST_SEND : ST_GUARD;
          end else begin
            cnt_d   = cnt_q + ONE_L;
          end
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_GUARD: begin
`ifdef CONFIG_TX_ABORT_EN
        if (abort) begin
          state_d = ST_GAP;
        end else
`endif
        if (gcnt_q == GUARD_LAST) begin
          cnt_d   = '0;
          state_d = ST_SEND;
        end else begin
          gcnt_d  = gcnt_q + 4'd1;
        end
      end
      ST_SEND: begin
        if (cnt_q == len_q - ONE_L) begin
          cnt_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d   = cnt_q + ONE_L;
        end
      end
      default: begin
        state_d = ST_TRACE;
      end
    endcase
  end

  // Output values for the coming cycle, decoded from the next state
  always_comb begin
    tracing_d  = 1'b1;
    cfg_id_d   = NULL_ID;
    cfg_data_d = 8'h00;
    busy_d     = (state_d != ST_TRACE);
    case (state_d)
      ST_TRACE: tracing_d = 1'b1;
      ST_LOAD:  tracing_d = !session_d;
      ST_GUARD: tracing_d = 1'b0;
      ST_GAP:   tracing_d = 1'b0;
      ST_SEND: begin
        tracing_d = 1'b0;
        cfg_id_d  = id_d;
        // A one-byte block can go straight from LOAD to SEND while byte 0 is still being written
        if (buf_we_s && (cnt_q[IW-1:0] == cnt_d[IW-1:0])) begin
          cfg_data_d = host.byte_data;
        end else begin
          cfg_data_d = fw_buf_q[cnt_d[IW-1:0]];
        end
      end
      default: tracing_d = 1'b1;
    endcase
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_TRACE;
      session_q  <= 1'b0;
      id_q       <= 8'h00;
      len_q      <= '0;
      cnt_q      <= '0;
      gcnt_q     <= 4'd0;
      tracing_q  <= 1'b1;
      cfg_id_q   <= NULL_ID;
      cfg_data_q <= 8'h00;
      busy_q     <= 1'b0;
      err_len_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      session_q  <= session_d;
      id_q       <= id_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      gcnt_q     <= gcnt_d;
      tracing_q  <= tracing_d;
      cfg_id_q   <= cfg_id_d;
      cfg_data_q <= cfg_data_d;
      busy_q     <= busy_d;
      err_len_q  <= err_len_d;
    end
  end

  // Firmware buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_BYTES; i++) begin
        fw_buf_q[i] <= 8'h00;
      end
    end else if (buf_we_s) begin
      fw_buf_q[cnt_q[IW-1:0]] <= host.byte_data;
    end
  end

  assign tracing    = tracing_q;
  assign configId   = cfg_id_q;
  assign configData = cfg_data_q;
  assign busy       = busy_q;
  assign err_len    = err_len_q;
endmodule

// File: tb/tb_config_stream_tx.sv
// tb_config_stream_tx: cycle table, hand-written corner sequences and randomized
// episodes checked against a per-cycle expectation built from the burst timing rules.
module tb_config_stream_tx;
  localparam int LW    = 5;
  localparam int GUARD = 2;

  typedef struct packed {
    logic          cv;
    logic [7:0]    cid;
    logic [LW-1:0] clen;
    logic          bv;
    logic [7:0]    bd;
  } stim_t;

  typedef struct packed {
    logic       tr;
    logic [7:0] id;
    logic [7:0] dat;
    logic       busy;
    logic       err;
    logic       cr;
    logic       br;
  } exp_t;

  typedef struct packed {
    stim_t s;
    exp_t  e;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tracing, busy, err_len;
  logic [7:0] configId, configData;
`ifdef CONFIG_TX_ABORT_EN
  logic       abort_in = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  stim_t sq[$];
  exp_t  eq[$];

  logic [7:0]    ep_id   [4];
  logic [LW-1:0] ep_len  [4];
  logic [7:0]    ep_b    [4][16];
  bit            ep_chain[4];
  int            ep_n;
  int            ep_gap;
  bit            ep_illegal;

  config_stream_tx_if #(.MAX_BYTES(16)) hif ();

  config_stream_tx #(.MAX_BYTES(16), .NULL_ID(8'hFF), .GUARD_CYCLES(GUARD)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef CONFIG_TX_ABORT_EN
    .abort      (abort_in),
`endif
    .host       (hif.slave),
    .tracing    (tracing),
    .configId   (configId),
    .configData (configData),
    .busy       (busy),
    .err_len    (err_len)
  );

  always #5 clk = ~clk;

  function automatic stim_t s_none();
    stim_t s;
    s = '0;
    return s;
  endfunction

  function automatic stim_t s_junk(bit allow_cmd, bit allow_byte);
    stim_t s;
    s.cv   = allow_cmd ? 1'($urandom) : 1'b0;
    s.cid  = 8'($urandom);
    s.clen = LW'($urandom);
    s.bv   = allow_byte ? 1'($urandom) : 1'b0;
    s.bd   = 8'($urandom);
    return s;
  endfunction

  function automatic stim_t s_cmd(logic [7:0] id, logic [LW-1:0] len);
    stim_t s;
    s      = s_junk(1'b0, 1'b1);
    s.cv   = 1'b1;
    s.cid  = id;
    s.clen = len;
    return s;
  endfunction

  function automatic stim_t s_byte(logic [7:0] d);
    stim_t s;
    s    = s_junk(1'b1, 1'b0);
    s.bv = 1'b1;
    s.bd = d;
    return s;
  endfunction

  function automatic exp_t e_idle(bit err);
    return '{1'b1, 8'hFF, 8'h00, 1'b0, err, 1'b1, 1'b0};
  endfunction
  function automatic exp_t e_load(bit tr);
    return '{tr, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1};
  endfunction
  function automatic exp_t e_guard();
    return '{1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic exp_t e_send(logic [7:0] id, logic [7:0] d);
    return '{1'b0, id, d, 1'b1, 1'b0, 1'b0, 1'b0};
  endfunction
  function automatic exp_t e_gap();
    return '{1'b0, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [7:0] rand_id();
    return 8'($urandom_range(0, 254));
  endfunction
  function automatic logic [LW-1:0] bad_len();
    return ($urandom_range(0, 1) == 0) ? LW'(0) : LW'($urandom_range(17, 31));
  endfunction

  task automatic cmp(string tag, string what, logic [7:0] act, logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s %s: got %0h expected %0h at %0t", tag, what, act, exp, $time);
    end
  endtask

  task automatic check(exp_t e, string tag);
    cmp(tag, "tracing",    {7'd0, tracing},        {7'd0, e.tr});
    cmp(tag, "configId",   configId,               e.id);
    cmp(tag, "configData", configData,             e.dat);
    cmp(tag, "busy",       {7'd0, busy},           {7'd0, e.busy});
    cmp(tag, "err_len",    {7'd0, err_len},        {7'd0, e.err});
    cmp(tag, "cmd_ready",  {7'd0, hif.cmd_ready},  {7'd0, e.cr});
    cmp(tag, "byte_ready", {7'd0, hif.byte_ready}, {7'd0, e.br});
  endtask

  task automatic drive(stim_t s);
    hif.cmd_valid  = s.cv;
    hif.cmd_id     = s.cid;
    hif.cmd_len    = s.clen;
    hif.byte_valid = s.bv;
    hif.byte_data  = s.bd;
  endtask

  task automatic add(stim_t s, exp_t e);
    sq.push_back(s);
    eq.push_back(e);
  endtask

  // Expected trace: TRACE idle, LOAD (len bytes plus stalls), GUARD (first of a session),
  // len burst cycles, one GAP cycle; a command offered in GAP chains without a second GUARD.
  task automatic build();
    bit session;
    bit err_pend;
    int g;
    session  = 1'b0;
    err_pend = 1'b0;
    for (int c = 0; c < ep_n; c++) begin
      if (!session) begin
        g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          add(s_junk(1'b0, 1'b1), e_idle(err_pend));
          err_pend = 1'b0;
        end
        if (ep_illegal && $urandom_range(0, 3) == 0) begin
          add(s_cmd(rand_id(), bad_len()), e_idle(err_pend));
          err_pend = 1'b1;
        end
        add(s_cmd(ep_id[c], ep_len[c]), e_idle(err_pend));
        err_pend = 1'b0;
      end
      for (int j = 0; j < int'(ep_len[c]); j++) begin
        g = (ep_gap < 0) ? $urandom_range(0, 2) : ep_gap;
        for (int k = 0; k < g; k++) add(s_junk(1'b1, 1'b0), e_load(!session));
        add(s_byte(ep_b[c][j]), e_load(!session));
      end
      if (!session) begin
        for (int k = 0; k < GUARD; k++) add(s_junk(1'b1, 1'b1), e_guard());
      end
      for (int j = 0; j < int'(ep_len[c]); j++) add(s_junk(1'b1, 1'b1), e_send(ep_id[c], ep_b[c][j]));
      if (c < ep_n - 1 && ep_chain[c]) begin
        add(s_cmd(ep_id[c+1], ep_len[c+1]), e_gap());
        session = 1'b1;
      end else if (ep_illegal && $urandom_range(0, 3) == 0) begin
        add(s_cmd(rand_id(), bad_len()), e_gap());
        err_pend = 1'b1;
        session  = 1'b0;
      end else begin
        add(s_junk(1'b0, 1'b1), e_gap());
        session = 1'b0;
      end
    end
    add(s_none(), e_idle(err_pend));
    add(s_none(), e_idle(1'b0));
  endtask

  task automatic run_queue(string tag);
    exp_t  e;
    stim_t s;
    while (eq.size() > 0) begin
      @(negedge clk);
      e = eq.pop_front();
      s = sq.pop_front();
      check(e, tag);
      drive(s);
    end
  endtask

  vec_t       tbl [17];
  logic [7:0] rb  [4];

  initial begin
    // single command id=3 len=4, then illegal lengths 0 and 17
    tbl[0]  = '{s_cmd(8'h03, 5'd4),   e_idle(1'b0)};
    tbl[1]  = '{s_byte(8'h11),        e_load(1'b1)};
    tbl[2]  = '{s_byte(8'h22),        e_load(1'b1)};
    tbl[3]  = '{s_byte(8'h33),        e_load(1'b1)};
    tbl[4]  = '{s_byte(8'h44),        e_load(1'b1)};
    tbl[5]  = '{s_none(),             e_guard()};
    tbl[6]  = '{s_none(),             e_guard()};
    tbl[7]  = '{s_none(),             e_send(8'h03, 8'h11)};
    tbl[8]  = '{s_none(),             e_send(8'h03, 8'h22)};
    tbl[9]  = '{s_none(),             e_send(8'h03, 8'h33)};
    tbl[10] = '{s_none(),             e_send(8'h03, 8'h44)};
    tbl[11] = '{s_none(),             e_gap()};
    tbl[12] = '{s_none(),             e_idle(1'b0)};
    tbl[13] = '{s_cmd(8'h03, 5'd0),   e_idle(1'b0)};
    tbl[14] = '{s_cmd(8'h03, 5'd17),  e_idle(1'b1)};
    tbl[15] = '{s_none(),             e_idle(1'b1)};
    tbl[16] = '{s_none(),             e_idle(1'b0)};

    drive(s_none());
    #12;
    check(e_idle(1'b0), "reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      check(tbl[i].e, "vec");
      drive(tbl[i].s);
    end

    // back-to-back: id 0 len 2 then id 1 len 3 offered in GAP
    ep_n = 2; ep_gap = 0; ep_illegal = 1'b0;
    ep_id[0] = 8'h00; ep_len[0] = 5'd2; ep_chain[0] = 1'b1;
    ep_id[1] = 8'h01; ep_len[1] = 5'd3; ep_chain[1] = 1'b0;
    for (int j = 0; j < 16; j++) begin
      ep_b[0][j] = 8'(8'h50 + j);
      ep_b[1][j] = 8'(8'h60 + j);
    end
    build();
    run_queue("b2b");

    // stalled loading: 3-cycle gaps before every byte
    ep_n = 1; ep_gap = 3; ep_id[0] = 8'h09; ep_len[0] = 5'd4; ep_chain[0] = 1'b0;
    build();
    run_queue("stall");

    for (int ep = 0; ep < 30; ep++) begin
      ep_n = $urandom_range(1, 4); ep_gap = -1; ep_illegal = 1'b1;
      for (int c = 0; c < 4; c++) begin
        ep_id[c]    = rand_id();
        ep_len[c]   = LW'($urandom_range(1, 16));
        ep_chain[c] = 1'($urandom);
        for (int j = 0; j < 16; j++) ep_b[c][j] = 8'($urandom);
      end
      build();
      run_queue("rand");
    end

    // reset while byte 2 of a len=4 burst is on the bus
    rb[0] = 8'hA0; rb[1] = 8'hA1; rb[2] = 8'hA2; rb[3] = 8'hA3;
    @(negedge clk); drive(s_cmd(8'h05, 5'd4));
    for (int j = 0; j < 4; j++) begin
      @(negedge clk); drive(s_byte(rb[j]));
    end
    @(negedge clk); drive(s_none()); check(e_guard(), "rst_guard");
    @(negedge clk);
    @(negedge clk); check(e_send(8'h05, rb[0]), "rst_send0");
    @(negedge clk);
    @(negedge clk); check(e_send(8'h05, rb[2]), "rst_send2");
    #2 rst_n = 1'b0;
    #1 check(e_idle(1'b0), "rst_async");
    @(negedge clk); check(e_idle(1'b0), "rst_hold"); rst_n = 1'b1;
    @(negedge clk); check(e_idle(1'b0), "rst_after");

`ifdef CONFIG_TX_ABORT_EN
    @(negedge clk); drive(s_cmd(8'h07, 5'd2));
    @(negedge clk); drive(s_byte(8'hB1));
    @(negedge clk); drive(s_byte(8'hB2));
    @(negedge clk); check(e_guard(), "abort_guard"); drive(s_none()); abort_in = 1'b1;
    @(negedge clk); check(e_gap(), "abort_gap"); abort_in = 1'b0;
    @(negedge clk); check(e_idle(1'b0), "abort_trace");
    @(negedge clk); drive(s_cmd(8'h07, 5'd3));
    @(negedge clk); check(e_load(1'b1), "abort_load0"); drive(s_byte(8'hC1));
    @(negedge clk); check(e_load(1'b1), "abort_load1"); drive(s_none()); abort_in = 1'b1;
    @(negedge clk); check(e_idle(1'b0), "abort_load_trace"); abort_in = 1'b0;
    @(negedge clk); check(e_idle(1'b0), "abort_idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
